// File: rtl/switch_toggle_bank_if.sv
// -----------------------------------------------------------------------------
// switch_toggle_bank_if
// Bundle that connects the switch/LED bank to the rest of the system.
//   i_Switch      : raw switch levels, bit n = channel n (driven by master)
//   o_LED         : per-channel toggle state (driven by slave)
//   o_Event       : one-cycle pulse per accepted active edge (driven by slave)
//   o_Event_Count : running event total, modulo 256 (driven by slave)
// Modports: master = board/status side, slave = switch_toggle_bank.
// -----------------------------------------------------------------------------
interface switch_toggle_bank_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0] i_Switch;
   logic [NUM_CH-1:0] o_LED;
   logic [NUM_CH-1:0] o_Event;
   logic [7:0]        o_Event_Count;

   modport master (
      output i_Switch,
      input  o_LED,
      input  o_Event,
      input  o_Event_Count
   );

   modport slave (
      input  i_Switch,
      output o_LED,
      output o_Event,
      output o_Event_Count
   );
endinterface

// File: rtl/switch_toggle_bank.sv
// -----------------------------------------------------------------------------
// switch_toggle_bank
// NUM_CH independent switch channels. Each channel debounces its raw input,
// detects the selected edge of the debounced level, toggles its LED on that
// edge and emits a one-cycle event pulse. A shared 8-bit counter totals all
// events (wrapping modulo 256).
//
// Ports:
//   i_Clk : system clock
//   i_Rst : synchronous, active-high reset
//   bus   : switch_toggle_bank_if.slave (i_Switch in; o_LED, o_Event,
//           o_Event_Count out; all outputs registered)
//
// Parameters:
//   NUM_CH         : channel count (1..16)
//   DEBOUNCE_LIMIT : cycles a changed input must hold before acceptance (>=2)
//   EDGE_MODE      : 0 = falling, 1 = rising, 2 = both
//
// Build option:
//   SWITCH_TOGGLE_SYNC_EN : when defined, each switch bit passes through a
//                           2-flop synchronizer first (adds 2 cycles latency).
// -----------------------------------------------------------------------------
module switch_toggle_bank #(
   parameter int NUM_CH         = 4,
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int EDGE_MODE      = 0
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   switch_toggle_bank_if.slave bus
);

   localparam int            CW    = $clog2(DEBOUNCE_LIMIT);
   localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_LIMIT - 1);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   // Number of set bits, used to add simultaneous events in one cycle.
   function automatic logic [7:0] popcount(input logic [NUM_CH-1:0] v);
      logic [7:0] n;
      n = 8'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         n = n + {7'd0, v[i]};
      end
      return n;
   endfunction

   logic [NUM_CH-1:0] x_s;
   logic [NUM_CH-1:0] stable_r;
   logic [NUM_CH-1:0] prev_r;
   logic [CW-1:0]     cnt_r [NUM_CH];
   logic [NUM_CH-1:0] led_r;
   logic [NUM_CH-1:0] event_r;
   logic [7:0]        event_count_r;
   logic [NUM_CH-1:0] rise_s;
   logic [NUM_CH-1:0] fall_s;
   logic [NUM_CH-1:0] active_s;

`ifdef SWITCH_TOGGLE_SYNC_EN
   logic [NUM_CH-1:0] sync1_r;
   logic [NUM_CH-1:0] sync2_r;

   // Two-flop synchronizer; cleared by reset so stale levels do not survive it.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         sync1_r <= {NUM_CH{1'b0}};
         sync2_r <= {NUM_CH{1'b0}};
      end else begin
         sync1_r <= bus.i_Switch;
         sync2_r <= sync1_r;
      end
   end

   assign x_s = sync2_r;
`else
   assign x_s = bus.i_Switch;
`endif

   // Per-channel debounce: a differing level must persist DEBOUNCE_LIMIT
   // samples; any return to the stable level restarts the count.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         stable_r <= {NUM_CH{1'b0}};
         prev_r   <= {NUM_CH{1'b0}};
         for (int n = 0; n < NUM_CH; n++) begin
            cnt_r[n] <= {CW{1'b0}};
         end
      end else begin
         prev_r <= stable_r;
         for (int n = 0; n < NUM_CH; n++) begin
            if (x_s[n] == stable_r[n]) begin
               cnt_r[n] <= {CW{1'b0}};
            end else if (cnt_r[n] == C_MAX) begin
               stable_r[n] <= x_s[n];
               cnt_r[n]    <= {CW{1'b0}};
            end else begin
               cnt_r[n] <= cnt_r[n] + C_ONE;
            end
         end
      end
   end

   // Edge select on the debounced level (stable vs. one cycle older copy).
   always_comb begin
      rise_s = stable_r & ~prev_r;
      fall_s = prev_r & ~stable_r;
      case (EDGE_MODE)
         32'sd0:  active_s = fall_s;
         32'sd1:  active_s = rise_s;
         32'sd2:  active_s = rise_s | fall_s;
         default: active_s = fall_s;
      endcase
   end

   // Registered outputs: LED toggle, event pulse and shared event total.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         led_r         <= {NUM_CH{1'b0}};
         event_r       <= {NUM_CH{1'b0}};
         event_count_r <= 8'd0;
      end else begin
         led_r         <= led_r ^ active_s;
         event_r       <= active_s;
         event_count_r <= event_count_r + popcount(active_s);
      end
   end

   assign bus.o_LED         = led_r;
   assign bus.o_Event       = event_r;
   assign bus.o_Event_Count = event_count_r;

endmodule

// File: tb/tb_switch_toggle_bank.sv
// -----------------------------------------------------------------------------
// tb_switch_toggle_bank
// Three instances (EDGE_MODE 0, 1, 2) share one switch stimulus. Accepted
// level changes push expected events (cycle, event vector, LED, count) into
// per-instance queues; a monitor per instance pops and compares whenever
// o_Event is non-zero. Directed final-state checks use hand-computed values.
// -----------------------------------------------------------------------------
module tb_switch_toggle_bank;
   localparam int LIMIT = 4;
`ifdef SWITCH_TOGGLE_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   typedef struct packed {
      int unsigned cyc;
      logic [7:0]  cnt;
      logic [3:0]  led;
      logic [3:0]  ev;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  sw  = 4'b0000;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   exp_t        exp_q [3][$];
   logic [3:0]  mlev;
   logic [3:0]  mled [3];
   logic [7:0]  mcnt [3];

   logic [3:0]  led_w [3];
   logic [3:0]  ev_w  [3];
   logic [7:0]  cnt_w [3];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   switch_toggle_bank_if #(.NUM_CH(4)) bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign bus[g].i_Switch = sw;
      assign led_w[g] = bus[g].o_LED;
      assign ev_w[g]  = bus[g].o_Event;
      assign cnt_w[g] = bus[g].o_Event_Count;

      switch_toggle_bank #(
         .NUM_CH(4),
         .DEBOUNCE_LIMIT(LIMIT),
         .EDGE_MODE(g)
      ) u_dut (
         .i_Clk(clk),
         .i_Rst(rst),
         .bus(bus[g])
      );

      // Monitor: every cycle with an event must match the next queued entry.
      always @(negedge clk) begin
         exp_t e;
         if (ev_w[g] != 4'b0000) begin
            checks++;
            if (exp_q[g].size() == 0) begin
               errors++;
               $display("FAIL unexpected_event mode%0d: cyc=%0d ev=%b led=%b cnt=%0d, required no event",
                        g, cyc, ev_w[g], led_w[g], cnt_w[g]);
            end else begin
               e = exp_q[g].pop_front();
               if (cyc != e.cyc || ev_w[g] != e.ev || led_w[g] != e.led || cnt_w[g] != e.cnt) begin
                  errors++;
                  $display("FAIL event mode%0d: got cyc=%0d ev=%b led=%b cnt=%0d, required cyc=%0d ev=%b led=%b cnt=%0d",
                           g, cyc, ev_w[g], led_w[g], cnt_w[g], e.cyc, e.ev, e.led, e.cnt);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic model_reset();
      mlev = 4'b0000;
      for (int d = 0; d < 3; d++) begin
         mled[d] = 4'b0000;
         mcnt[d] = 8'd0;
      end
   endtask

   // Drive a level that will be held long enough to be accepted; the event
   // shows up 5 edges after this drive point (first sample + LIMIT), plus LAT.
   task automatic apply(input logic [3:0] v);
      logic [3:0] act;
      exp_t       e;
      for (int d = 0; d < 3; d++) begin
         case (d)
            0:       act = mlev & ~v;
            1:       act = v & ~mlev;
            default: act = v ^ mlev;
         endcase
         if (act != 4'b0000) begin
            mled[d] = mled[d] ^ act;
            mcnt[d] = mcnt[d] + 8'($countones(act));
            e.cyc = cyc + 32'd5 + LAT;
            e.cnt = mcnt[d];
            e.led = mled[d];
            e.ev  = act;
            exp_q[d].push_back(e);
         end
      end
      mlev = v;
      sw   = v;
   endtask

   initial begin
      model_reset();

      // Reset state
      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_led_m%0d", d), int'(led_w[d]), 0);
         chk($sformatf("reset_ev_m%0d", d),  int'(ev_w[d]),  0);
         chk($sformatf("reset_cnt_m%0d", d), int'(cnt_w[d]), 0);
      end
      rst = 1'b0;

      // Glitch of LIMIT-1 samples must be discarded
      sw = 4'b0001;
      repeat (3) tick();
      sw = 4'b0000;
      repeat (10) tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("glitch_led_m%0d", d), int'(led_w[d]), 0);
         chk($sformatf("glitch_cnt_m%0d", d), int'(cnt_w[d]), 0);
      end

      // Single press: ch0 high 10 cycles, then low 10 cycles
      apply(4'b0001);
      repeat (10) tick();
      apply(4'b0000);
      repeat (10) tick();
      chk("press_led_m0", int'(led_w[0]), 1);
      chk("press_cnt_m0", int'(cnt_w[0]), 1);
      chk("press_led_m1", int'(led_w[1]), 1);
      chk("press_cnt_m1", int'(cnt_w[1]), 1);
      chk("press_led_m2", int'(led_w[2]), 0);
      chk("press_cnt_m2", int'(cnt_w[2]), 2);

      // Reset between scenarios
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst2_cnt_m%0d", d), int'(cnt_w[d]), 0);
      end

      // Simultaneous edges on all channels, 64 times: counters wrap
      for (int k = 0; k < 64; k++) begin
         apply(4'b1111);
         repeat (6) tick();
         apply(4'b0000);
         repeat (6) tick();
         if (k == 31) begin
            chk("wrap_half_cnt_m1", int'(cnt_w[1]), 128);
            chk("wrap_half_cnt_m2", int'(cnt_w[2]), 0);
         end
      end
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("wrap_cnt_m%0d", d), int'(cnt_w[d]), 0);
         chk($sformatf("wrap_led_m%0d", d), int'(led_w[d]), 0);
      end

      // Reset in the middle of a ch1 debounce, released with ch1 still high
      sw = 4'b0010;
      tick();
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      apply(4'b0010);
      repeat (12) tick();
      chk("midrst_led_m1", int'(led_w[1]), 2);
      chk("midrst_cnt_m1", int'(cnt_w[1]), 1);
      chk("midrst_cnt_m0", int'(cnt_w[0]), 0);

      // Every expected event must have been observed
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("pending_events_m%0d", d), exp_q[d].size(), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
